// File: rtl/mandel_iterate.sv
// Escape-time Mandelbrot iteration engine: iterates z <= z^2 + c one step per
// clock and reports the iteration count at escape or at the latched limit.
module mandel_iterate #(
  parameter int unsigned PIXEL_DATA_WIDTH   = 10,
  parameter int unsigned ENGINE_DATA_WIDTH  = 25,
  parameter int unsigned ENGINE_FRACT_WIDTH = 20,
  parameter int unsigned ITER_WIDTH         = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] real_x,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] imag_y,
  input  logic [PIXEL_DATA_WIDTH-1:0]         pixel_x_in,
  input  logic [PIXEL_DATA_WIDTH-1:0]         pixel_y_in,
  input  logic [ITER_WIDTH-1:0]               max_iter,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ITER_WIDTH-1:0]               iterations,
  output logic                                escaped,
  output logic [PIXEL_DATA_WIDTH-1:0]         pixel_x_out,
  output logic [PIXEL_DATA_WIDTH-1:0]         pixel_y_out
);

  localparam int unsigned PROD_WIDTH = 2 * ENGINE_DATA_WIDTH + 1;
  localparam logic signed [PROD_WIDTH-1:0] MAG_LIMIT =
    PROD_WIDTH'(4) << (2 * ENGINE_FRACT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic signed [ENGINE_DATA_WIDTH-1:0] zr, zi, cr, ci;
  logic [ITER_WIDTH-1:0]               count, limit;
  logic [PIXEL_DATA_WIDTH-1:0]         tag_x, tag_y;

  logic signed [PROD_WIDTH-1:0]        zr_ext, zi_ext;
  logic signed [PROD_WIDTH-1:0]        zr_sq, zi_sq, zr_zi;
  logic signed [PROD_WIDTH-1:0]        mag, re_full, im_full;
  logic signed [ENGINE_DATA_WIDTH-1:0] zr_next, zi_next;
  logic                                escape;

  // Full-precision squares: products carry 2*FRACT fraction bits.
  assign zr_ext  = PROD_WIDTH'(zr);
  assign zi_ext  = PROD_WIDTH'(zi);
  assign zr_sq   = zr_ext * zr_ext;
  assign zi_sq   = zi_ext * zi_ext;
  assign zr_zi   = zr_ext * zi_ext;
  assign mag     = zr_sq + zi_sq;
  assign re_full = zr_sq - zi_sq;
  assign im_full = zr_zi <<< 1;
  assign escape  = (mag > MAG_LIMIT);

  // Floor shift back to the engine format, then wrap to the word width.
  assign zr_next = ENGINE_DATA_WIDTH'(re_full >>> ENGINE_FRACT_WIDTH) + cr;
  assign zi_next = ENGINE_DATA_WIDTH'(im_full >>> ENGINE_FRACT_WIDTH) + ci;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      zr          <= '0;
      zi          <= '0;
      cr          <= '0;
      ci          <= '0;
      count       <= '0;
      limit       <= '0;
      tag_x       <= '0;
      tag_y       <= '0;
      iterations  <= '0;
      escaped     <= 1'b0;
      pixel_x_out <= '0;
      pixel_y_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cr    <= real_x;
            ci    <= imag_y;
            tag_x <= pixel_x_in;
            tag_y <= pixel_y_in;
            limit <= max_iter;
            zr    <= '0;
            zi    <= '0;
            count <= '0;
            state <= ITER;
          end
        end
        ITER: begin
          if (escape || (count == limit)) begin
            iterations  <= count;
            escaped     <= escape;
            pixel_x_out <= tag_x;
            pixel_y_out <= tag_y;
            state       <= DONE;
          end else begin
            zr    <= zr_next;
            zi    <= zi_next;
            count <= count + ITER_WIDTH'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_iterate.sv
// Self-checking bench for mandel_iterate: vector table through a result
// scoreboard, plus hand-written reset and backpressure sequences.
module tb_mandel_iterate;

  localparam int unsigned PW = 10;
  localparam int unsigned DW = 25;
  localparam int unsigned IW = 16;

  localparam logic [DW-1:0] ONE      = 25'h0100000;
  localparam logic [DW-1:0] TWO      = 25'h0200000;
  localparam logic [DW-1:0] NEG_ONE  = 25'h1F00000;
  localparam logic [DW-1:0] NEG_TWO  = 25'h1E00000;
  localparam logic [DW-1:0] QUARTER  = 25'h0040000;
  localparam logic [DW-1:0] HALF     = 25'h0080000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] real_x, imag_y;
  logic [PW-1:0] pixel_x_in, pixel_y_in;
  logic [IW-1:0] max_iter;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] iterations;
  logic          escaped;
  logic [PW-1:0] pixel_x_out, pixel_y_out;

  mandel_iterate dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .real_x     (real_x),
    .imag_y     (imag_y),
    .pixel_x_in (pixel_x_in),
    .pixel_y_in (pixel_y_in),
    .max_iter   (max_iter),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .iterations (iterations),
    .escaped    (escaped),
    .pixel_x_out(pixel_x_out),
    .pixel_y_out(pixel_y_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] cr;
    logic [DW-1:0] ci;
    logic [PW-1:0] px;
    logic [PW-1:0] py;
    logic [IW-1:0] lim;
    logic [IW-1:0] exp_iter;
    logic          exp_esc;
    int            exp_lat;
  } vec_t;

  typedef struct {
    logic [IW-1:0] iter;
    logic          esc;
    logic [PW-1:0] px;
    logic [PW-1:0] py;
    int            lat;
  } res_t;

  vec_t vecs[7];
  res_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wait for out_valid after an accept edge; returns edges counted from the accept edge.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      n_vec++;
      n_fail++;
      $display("FAIL timeout: no out_valid after %0d cycles", lat);
    end
  endtask

  task automatic compare_result(input int lat);
    res_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard: result with empty queue");
      return;
    end
    e = sb.pop_front();
    check("iterations",  32'(iterations),  32'(e.iter));
    check("escaped",     32'(escaped),     32'(e.esc));
    check("pixel_x_out", 32'(pixel_x_out), 32'(e.px));
    check("pixel_y_out", 32'(pixel_y_out), 32'(e.py));
    check("latency",     32'(lat),         32'(e.lat));
  endtask

  task automatic drive_point(input logic [DW-1:0] cr, input logic [DW-1:0] ci,
                             input logic [PW-1:0] px, input logic [PW-1:0] py,
                             input logic [IW-1:0] lim);
    in_valid   = 1'b1;
    real_x     = cr;
    imag_y     = ci;
    pixel_x_in = px;
    pixel_y_in = py;
    max_iter   = lim;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    drive_point(v.cr, v.ci, v.px, v.py, v.lim);
    out_ready = 1'b1;
    @(posedge clk);
    sb.push_back('{iter: v.exp_iter, esc: v.exp_esc, px: v.px, py: v.py, lat: v.exp_lat});
    #1;
    in_valid = 1'b0;
    check("in_ready_busy", 32'(in_ready), 32'd0);
    wait_result(lat);
    if (out_valid) compare_result(lat);
    else void'(sb.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int stale;

    //                cr       ci    px  py  lim  iter esc lat
    vecs[0] = '{ONE,     '0,   5,  7,  100, 3,  1'b1, 5};
    vecs[1] = '{TWO,     '0,   1,  2,  100, 2,  1'b1, 4};
    vecs[2] = '{NEG_ONE, '0,   8,  9,  50,  50, 1'b0, 52};
    vecs[3] = '{HALF,    '0,   0,  0,  0,   0,  1'b0, 2};
    vecs[4] = '{QUARTER, '0,   1023, 1023, 20, 20, 1'b0, 22};
    vecs[5] = '{'0,      TWO,  12, 34, 100, 2,  1'b1, 4};
    vecs[6] = '{NEG_TWO, '0,   6,  6,  30,  30, 1'b0, 32};

    reset_n    = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    real_x     = '0;
    imag_y     = '0;
    pixel_x_in = '0;
    pixel_y_in = '0;
    max_iter   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_iterations", 32'(iterations), 32'd0);
    check("rst_escaped",    32'(escaped),    32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Backpressure: result held while a second point waits on the input.
    @(negedge clk);
    drive_point(ONE, '0, 3, 4, 100);
    out_ready = 1'b0;
    @(posedge clk);
    sb.push_back('{iter: 3, esc: 1'b1, px: 3, py: 4, lat: 5});
    #1;
    drive_point(QUARTER, '0, 9, 11, 20);
    wait_result(lat);
    compare_result(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid",  32'(out_valid),   32'd1);
      check("bp_in_ready",   32'(in_ready),    32'd0);
      check("bp_iterations", 32'(iterations),  32'd3);
      check("bp_escaped",    32'(escaped),     32'd1);
      check("bp_pixel_x",    32'(pixel_x_out), 32'd3);
      check("bp_pixel_y",    32'(pixel_y_out), 32'd4);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    sb.push_back('{iter: 20, esc: 1'b0, px: 9, py: 11, lat: 22});
    #1;
    in_valid = 1'b0;
    check("bp_second_accepted", 32'(in_ready), 32'd0);
    wait_result(lat);
    compare_result(lat);
    out_ready = 1'b0;

    // Reset in the middle of an iteration: nothing may come out afterwards.
    @(negedge clk);
    drive_point(NEG_ONE, '0, 1, 2, 100);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid",  32'(out_valid),   32'd0);
    check("midrst_iterations", 32'(iterations),  32'd0);
    check("midrst_escaped",    32'(escaped),     32'd0);
    check("midrst_pixel_x",    32'(pixel_x_out), 32'd0);
    check("midrst_pixel_y",    32'(pixel_y_out), 32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("midrst_no_stale", 32'(stale), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mandel_iterate.md
Name: mandel_iterate

Overview:
- Escape-time iteration engine that sits directly downstream of the pixel-to-complex mapping stage.
- Accepts one complex point c = (real_x, imag_y) with its pixel coordinates.
- Iterates z(n+1) = z(n)^2 + c from z0 = 0, one iteration per clock.
- Returns the iteration count at escape (|z|^2 > 4.0) or at the iteration limit, tagged with the pixel coordinates, for the colour/framebuffer stage.

Parameters:
- PIXEL_DATA_WIDTH, 10, width of pixel x/y coordinates.
- ENGINE_DATA_WIDTH, 25, signed fixed-point word width for c and z.
- ENGINE_FRACT_WIDTH, 20, fractional bits (Q5.20 at defaults).
- ITER_WIDTH, 16, width of the iteration limit and count.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input point valid.
- in_ready  out  1  engine can accept a point.
- real_x  in  ENGINE_DATA_WIDTH  signed real part of c.
- imag_y  in  ENGINE_DATA_WIDTH  signed imaginary part of c.
- pixel_x_in  in  PIXEL_DATA_WIDTH  pixel x tag.
- pixel_y_in  in  PIXEL_DATA_WIDTH  pixel y tag.
- max_iter  in  ITER_WIDTH  iteration limit, latched on accept.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- iterations  out  ITER_WIDTH  iteration count.
- escaped  out  1  1 = escaped, 0 = limit reached.
- pixel_x_out  out  PIXEL_DATA_WIDTH  pixel x tag of the result.
- pixel_y_out  out  PIXEL_DATA_WIDTH  pixel y tag of the result.

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE.
  - zr, zi, count, iterations, escaped, pixel_x_out, pixel_y_out, latched c and limit all 0.
  - out_valid=0.
  - in_ready=1 once in IDLE.
  - Reset mid-iteration aborts the point; no result is emitted.
- Outputs: in_ready = (state==IDLE); out_valid = (state==DONE). Both are decoded from registered state, not from inputs.
- IDLE: on in_valid&&in_ready, latch real_x, imag_y, pixel tags and max_iter; zr=zi=0; count=0; go to ITER.
- ITER, each cycle, with priority:
  1. mag = zr*zr + zi*zi, computed at full precision (2*ENGINE_DATA_WIDTH+1 bits, 2*ENGINE_FRACT_WIDTH fraction bits). If mag > 4<<(2*ENGINE_FRACT_WIDTH): iterations=count, escaped=1, go to DONE.
  2. Else if count==max_iter (latched): iterations=count, escaped=0, go to DONE.
  3. Else update:
     - zr <= ((zr*zr - zi*zi) >>> ENGINE_FRACT_WIDTH) + cr
     - zi <= ((2*zr*zi) >>> ENGINE_FRACT_WIDTH) + ci
     - count <= count+1
     - Arithmetic shift (floor); result truncated to ENGINE_DATA_WIDTH.
- Overflow:
  - An update only occurs with |z|^2 <= 4, so squared terms stay within +-4.
  - No overflow is guaranteed for |cr|,|ci| < 8.0.
  - Outside that range z wraps two's-complement; this is legal but not checked.
- Latency: accept to out_valid = (final count + 2) cycles, i.e. count+1 cycles in ITER plus 1.
- max_iter=0: one ITER cycle, then DONE with iterations=0, escaped=0.
- DONE:
  - Hold out_valid and all result outputs stable until out_ready.
  - On out_valid&&out_ready go to IDLE.
  - No input is accepted in DONE, so accept and output never coincide.
  - out_ready high before DONE has no effect.
- Input signals while in_ready=0 are ignored; latched values are not disturbed.

Test Plan:
- Reset: assert reset_n=0 mid-ITER (c=-1.0, max_iter=100) -> out_valid=0 and all outputs 0 immediately; after release in_ready=1; no stale result is ever emitted.
- c=1.0+0i (real_x=0x100000, imag_y=0), max_iter=100, pixel (5,7), out_ready=1 -> z sequence 0,1,2,5; out_valid asserted 5 cycles after accept; iterations=3, escaped=1, pixel_x_out=5, pixel_y_out=7.
- c=2.0+0i, max_iter=100 -> iterations=2, escaped=1. This confirms the boundary: |z|^2=4 exactly does not escape.
- c=-1.0+0i, max_iter=50 -> oscillates 0/-1, iterations=50, escaped=0; out_valid 52 cycles after accept.
- max_iter=0, any c -> iterations=0, escaped=0, out_valid 2 cycles after accept.
- Backpressure: c=1.0 with out_ready=0 for 10 cycles -> out_valid and outputs held stable and in_ready=0 throughout. Then out_ready=1 for one cycle -> IDLE, in_ready=1 next cycle. A second queued point (c=0.25+0i, max_iter=20) is accepted and returns iterations=20, escaped=0.
